rbsp_bit_window: RTL and testbench

RBSP_BIT_WINDOW -- requirements
Module: rbsp_bit_window

---
 rtl/rbsp_bit_window_pkg.sv | 14 +
 rtl/rbsp_bit_window_lzc8.sv | 13 +
 rtl/rbsp_bit_window.sv | 101 ++++++++++
 tb/tb_rbsp_bit_window.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rbsp_bit_window_pkg.sv
// Shared types and constants for the RBSP bit window: FSM encoding, buffer geometry,
// and the emulation-prevention byte value.
package rbsp_bit_window_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    localparam int          BUF_W    = 32;
    localparam int          CNT_W    = 6;
    localparam logic [7:0]  EMU_BYTE = 8'h03;
    localparam logic [3:0]  MAX_FWD  = 4'd8;
endpackage

// File: rtl/rbsp_bit_window_lzc8.sv
// Combinational leading-zero counter for one byte; an all-zero input yields 8.
module lzc8 (
    input  logic [7:0] d,
    output logic [3:0] cnt
);
    always_comb begin
        cnt = 4'd8;
        // Scan upward so the highest set bit is the last one to write cnt.
        for (int i = 0; i < 8; i++) begin
            if (d[i]) cnt = 4'(7 - i);
        end
    end
endmodule

// File: rtl/rbsp_bit_window.sv
// Byte-to-bit window for an RBSP parser: strips emulation-prevention bytes and
// exposes the next 8 unread bits, consuming 0..8 bits per cycle.
module rbsp_bit_window
    import rbsp_bit_window_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_nal_start,
    input  logic [7:0] i_byte,
    input  logic       i_byte_valid,
    output logic       o_byte_ready,
    input  logic [3:0] i_forward_len,
    output logic [7:0] o_rbsp_in,
    output logic [3:0] o_num_zero_bits,
    output logic       o_window_valid,
    output logic       o_emu_drop
);
    state_t               state, state_nxt;
    logic [BUF_W-1:0]     bits_q;
    logic [CNT_W-1:0]     bit_cnt;
    logic [1:0]           zero_run;
    logic                 emu_drop_q;

    logic                 window_valid;
    logic [3:0]           fwd;
    logic [CNT_W-1:0]     rem;
    logic                 byte_ready;
    logic                 xfer;
    logic                 is_emu;
    logic                 append;
    logic [3:0]           lz;

    // Consumption only counts while a full window is present, so bit_cnt cannot underflow.
    always_comb begin
        window_valid = (bit_cnt >= CNT_W'(8));
        fwd          = 4'd0;
        if (window_valid) fwd = (i_forward_len > MAX_FWD) ? MAX_FWD : i_forward_len;
        rem          = bit_cnt - {2'b00, fwd};
        byte_ready   = (state == ST_STREAM) && !i_nal_start && (rem <= CNT_W'(24));
        xfer         = byte_ready && i_byte_valid;
        is_emu       = xfer && (i_byte == EMU_BYTE) && (zero_run == 2'd2);
        append       = xfer && !is_emu;
    end

    always_comb begin
        state_nxt = state;
        if (i_nal_start) begin
            state_nxt = ST_FLUSH;
        end else begin
            case (state)
                ST_IDLE:   state_nxt = ST_IDLE;
                ST_FLUSH:  state_nxt = ST_STREAM;
                ST_STREAM: state_nxt = ST_STREAM;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bits_q     <= '0;
            bit_cnt    <= '0;
            zero_run   <= '0;
            emu_drop_q <= 1'b0;
        end else if (i_nal_start || state == ST_FLUSH) begin
            bits_q     <= '0;
            bit_cnt    <= '0;
            zero_run   <= '0;
            emu_drop_q <= 1'b0;
        end else if (state == ST_STREAM) begin
            // New byte lands directly after the bits that survive this cycle's shift.
            bits_q     <= (bits_q << fwd) | (append ? ({i_byte, 24'h0} >> rem) : '0);
            bit_cnt    <= rem + (append ? CNT_W'(8) : CNT_W'(0));
            emu_drop_q <= is_emu;
            if (append) begin
                if (i_byte != 8'h00)      zero_run <= 2'd0;
                else if (zero_run != 2'd2) zero_run <= zero_run + 2'd1;
            end else if (is_emu) begin
                zero_run <= 2'd0;
            end
        end else begin
            emu_drop_q <= 1'b0;
        end
    end

    lzc8 u_lzc (
        .d   (bits_q[BUF_W-1 -: 8]),
        .cnt (lz)
    );

    assign o_byte_ready    = byte_ready;
    assign o_window_valid  = window_valid;
    assign o_rbsp_in       = window_valid ? bits_q[BUF_W-1 -: 8] : 8'h00;
    assign o_num_zero_bits = window_valid ? lz : 4'd8;
    assign o_emu_drop      = emu_drop_q;
endmodule

// File: tb/tb_rbsp_bit_window.sv
// Directed bench for rbsp_bit_window: flush, emulation-prevention drop, full buffer,
// drain past empty, and reset / restart mid-stream.
module tb_rbsp_bit_window;
    logic       clk = 1'b0;
    logic       rst;
    logic       i_nal_start;
    logic [7:0] i_byte;
    logic       i_byte_valid;
    logic       o_byte_ready;
    logic [3:0] i_forward_len;
    logic [7:0] o_rbsp_in;
    logic [3:0] o_num_zero_bits;
    logic       o_window_valid;
    logic       o_emu_drop;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rbsp_bit_window dut (
        .clk             (clk),
        .rst             (rst),
        .i_nal_start     (i_nal_start),
        .i_byte          (i_byte),
        .i_byte_valid    (i_byte_valid),
        .o_byte_ready    (o_byte_ready),
        .i_forward_len   (i_forward_len),
        .o_rbsp_in       (o_rbsp_in),
        .o_num_zero_bits (o_num_zero_bits),
        .o_window_valid  (o_window_valid),
        .o_emu_drop      (o_emu_drop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Window snapshot: valid, bits, leading zeros, drop pulse.
    task automatic win(input string tag, input logic v, input logic [7:0] b,
                       input logic [3:0] z, input logic e);
        check({tag, ".valid"}, 32'(o_window_valid), 32'(v));
        check({tag, ".rbsp"},  32'(o_rbsp_in), 32'(b));
        check({tag, ".zeros"}, 32'(o_num_zero_bits), 32'(z));
        check({tag, ".emu"},   32'(o_emu_drop), 32'(e));
    endtask

    task automatic push(input logic [7:0] b, input logic [3:0] f);
        i_byte = b; i_byte_valid = 1'b1; i_forward_len = f;
        step();
        i_byte_valid = 1'b0; i_forward_len = 4'd0;
    endtask

    task automatic fwd(input logic [3:0] f);
        i_byte_valid = 1'b0; i_forward_len = f;
        step();
        i_forward_len = 4'd0;
    endtask

    task automatic nal();
        i_nal_start = 1'b1;
        step();
        i_nal_start = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b0; i_nal_start = 1'b0; i_byte = 8'h00;
        i_byte_valid = 1'b0; i_forward_len = 4'd0;
        #12;
        win("reset", 1'b0, 8'h00, 4'd8, 1'b0);
        check("reset.ready", 32'(o_byte_ready), 32'd0);
        step();
        rst = 1'b1;
        step();
        check("idle.ready", 32'(o_byte_ready), 32'd0);

        // Basic window and 1-bit forward
        i_nal_start = 1'b1;
        step();
        i_nal_start = 1'b0;
        check("flush.ready", 32'(o_byte_ready), 32'd0);
        step();
        check("stream.ready", 32'(o_byte_ready), 32'd1);
        push(8'h40, 4'd0);
        win("s1.b0", 1'b1, 8'h40, 4'd1, 1'b0);
        push(8'h01, 4'd0);
        win("s1.b1", 1'b1, 8'h40, 4'd1, 1'b0);
        fwd(4'd1);
        win("s1.f1", 1'b1, 8'h80, 4'd0, 1'b0);

        // 00 00 03 01: 03 dropped
        nal();
        win("s2.flush", 1'b0, 8'h00, 4'd8, 1'b0);
        push(8'h00, 4'd0);
        win("s2.b0", 1'b1, 8'h00, 4'd8, 1'b0);
        push(8'h00, 4'd0);
        check("s2.b1.emu", 32'(o_emu_drop), 32'd0);
        push(8'h03, 4'd0);
        check("s2.drop.emu", 32'(o_emu_drop), 32'd1);
        push(8'h01, 4'd0);
        win("s2.w0", 1'b1, 8'h00, 4'd8, 1'b0);
        fwd(4'd8);
        win("s2.w1", 1'b1, 8'h00, 4'd8, 1'b0);
        fwd(4'd8);
        win("s2.w2", 1'b1, 8'h01, 4'd7, 1'b0);
        fwd(4'd8);
        win("s2.empty", 1'b0, 8'h00, 4'd8, 1'b0);

        // 00 00 00 03: three zero bytes survive, 03 dropped
        nal();
        push(8'h00, 4'd0);
        push(8'h00, 4'd0);
        push(8'h00, 4'd0);
        push(8'h03, 4'd0);
        check("s3.drop.emu", 32'(o_emu_drop), 32'd1);
        win("s3.w0", 1'b1, 8'h00, 4'd8, 1'b1);
        fwd(4'd8);
        win("s3.w1", 1'b1, 8'h00, 4'd8, 1'b0);
        fwd(4'd8);
        win("s3.w2", 1'b1, 8'h00, 4'd8, 1'b0);
        fwd(4'd8);
        win("s3.empty", 1'b0, 8'h00, 4'd8, 1'b0);

        // Fill to 32 bits, then forward 8 while a byte waits
        nal();
        i_byte_valid = 1'b1;
        i_byte = 8'h11; step();
        i_byte = 8'h22; step();
        i_byte = 8'h33; step();
        i_byte = 8'h44; step();
        i_byte = 8'h55; #1;
        check("s4.full.ready", 32'(o_byte_ready), 32'd0);
        win("s4.full", 1'b1, 8'h11, 4'd3, 1'b0);
        step();
        win("s4.held", 1'b1, 8'h11, 4'd3, 1'b0);
        i_forward_len = 4'd8; #1;
        check("s4.fwd.ready", 32'(o_byte_ready), 32'd1);
        step();
        i_forward_len = 4'd0; #1;
        win("s4.after", 1'b1, 8'h22, 4'd2, 1'b0);
        check("s4.still_full.ready", 32'(o_byte_ready), 32'd0);
        i_byte_valid = 1'b0;
        fwd(4'd8); fwd(4'd8); fwd(4'd8);
        win("s4.last", 1'b1, 8'h55, 4'd1, 1'b0);

        // Drain past empty with forward 8 every cycle, clamp of 15 to 8
        nal();
        push(8'hA5, 4'd0);
        push(8'h5A, 4'd0);
        fwd(4'd15);
        win("s5.w1", 1'b1, 8'h5A, 4'd1, 1'b0);
        fwd(4'd8);
        win("s5.empty", 1'b0, 8'h00, 4'd8, 1'b0);
        fwd(4'd8);
        win("s5.under", 1'b0, 8'h00, 4'd8, 1'b0);
        i_forward_len = 4'd8; #1;
        check("s5.empty.ready", 32'(o_byte_ready), 32'd1);
        push(8'hC3, 4'd8);
        win("s5.refill", 1'b1, 8'hC3, 4'd0, 1'b0);

        // Reset mid-stream, then restart and a mid-stream nal_start
        push(8'h7E, 4'd0);
        #2 rst = 1'b0; #1;
        win("s6.rst", 1'b0, 8'h00, 4'd8, 1'b0);
        check("s6.rst.ready", 32'(o_byte_ready), 32'd0);
        step();
        rst = 1'b1;
        step();
        check("s6.idle.ready", 32'(o_byte_ready), 32'd0);
        nal();
        push(8'h9C, 4'd0);
        win("s6.b0", 1'b1, 8'h9C, 4'd0, 1'b0);
        i_nal_start = 1'b1; i_forward_len = 4'd8;
        step();
        i_nal_start = 1'b0; i_forward_len = 4'd0;
        win("s6.flush", 1'b0, 8'h00, 4'd8, 1'b0);
        check("s6.flush.ready", 32'(o_byte_ready), 32'd0);
        step();
        push(8'h3C, 4'd0);
        win("s6.b1", 1'b1, 8'h3C, 4'd2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
